// File: rtl/ram_access_controller.sv
// ram_access_controller
//   Sole master of the byte-addressed 512-byte RAM. It sequences the RAM's
//   enable/mfc handshake and arbitrates round-robin between the instruction
//   fetch port (word reads) and the data port (byte/half/word/doubleword,
//   read or write). A doubleword becomes two word beats, high word first.
//   Each ACCESS or RELEASE wait is bounded by TIMEOUT cycles; on expiry the
//   transaction completes with err=1 and zeroed read data.
//
//   Request handshake: a requester raises req with stable fields and holds
//   it until it sees its one-cycle done pulse, then drops req in the next
//   cycle. req is only looked at in IDLE; a req still high there is taken
//   as a new request.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request and byte address
//   if_done/if_rdata            fetch completion pulse, fetched word (held)
//   d_req/d_rw/d_len/d_addr     data request: rw 1=read, len 0..3=B/H/W/D
//   d_wdata                     write data, right aligned
//   d_done/d_rdata              data completion pulse, read data (held)
//   err                         timeout flag, pulses with the done pulse
//   ram_*                       RAM pins (enable, read_write, length, addr,
//                               data in/out, mfc)
//   busy                        high whenever the FSM is not IDLE
module ram_access_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [8:0]  if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_len,
    input  logic [8:0]  d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic        err,
    output logic        ram_enable,
    output logic        ram_read_write,
    output logic [1:0]  ram_data_length,
    output logic [8:0]  ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    input  logic        ram_mfc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       LEN_WORD = 2'd2;
    localparam logic [1:0]       LEN_DW   = 2'd3;

    // Current state
    state_t      r_state;
    logic        r_grant_data;   // 1 = data port owns the transaction
    logic        r_last_data;    // round-robin: last grant went to data
    logic        r_beat;         // 1 = second word of a doubleword
    logic [CNT_W-1:0] r_cnt;
    logic [8:0]  r_addr;
    logic [1:0]  r_len;
    logic        r_rw;
    logic [63:0] r_wdata;
    logic [63:0] r_acc;          // read data gathered over the beats
    logic        r_err_pend;
    logic        r_if_done, r_d_done, r_err, r_busy;
    logic [31:0] r_if_rdata;
    logic [63:0] r_d_rdata;
    logic        r_ram_enable, r_ram_rw;
    logic [1:0]  r_ram_len;
    logic [8:0]  r_ram_addr;
    logic [31:0] r_ram_din;

    // Next values
    state_t      w_state_nxt;
    logic        w_grant_data_nxt, w_last_data_nxt, w_beat_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [8:0]  w_addr_nxt;
    logic [1:0]  w_len_nxt;
    logic        w_rw_nxt;
    logic [63:0] w_wdata_nxt, w_acc_nxt;
    logic        w_err_pend_nxt;
    logic        w_if_done_nxt, w_d_done_nxt, w_err_nxt, w_busy_nxt;
    logic [31:0] w_if_rdata_nxt;
    logic [63:0] w_d_rdata_nxt;
    logic        w_ram_enable_nxt, w_ram_rw_nxt;
    logic [1:0]  w_ram_len_nxt;
    logic [8:0]  w_ram_addr_nxt;
    logic [31:0] w_ram_din_nxt;
    logic        w_pick_data;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_data_nxt = r_grant_data;
        w_last_data_nxt  = r_last_data;
        w_beat_nxt       = r_beat;
        w_cnt_nxt        = r_cnt;
        w_addr_nxt       = r_addr;
        w_len_nxt        = r_len;
        w_rw_nxt         = r_rw;
        w_wdata_nxt      = r_wdata;
        w_acc_nxt        = r_acc;
        w_err_pend_nxt   = r_err_pend;
        w_if_done_nxt    = 1'b0;
        w_d_done_nxt     = 1'b0;
        w_err_nxt        = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_ram_enable_nxt = r_ram_enable;
        w_ram_rw_nxt     = r_ram_rw;
        w_ram_len_nxt    = r_ram_len;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_din_nxt    = r_ram_din;
        w_pick_data      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (if_req || d_req) begin
                    // With both pending, serve whichever was not served last.
                    w_pick_data      = d_req && (!if_req || !r_last_data);
                    w_grant_data_nxt = w_pick_data;
                    w_last_data_nxt  = w_pick_data;
                    w_beat_nxt       = 1'b0;
                    w_cnt_nxt        = '0;
                    w_err_pend_nxt   = 1'b0;
                    if (w_pick_data) begin
                        w_addr_nxt     = d_addr;
                        w_len_nxt      = d_len;
                        w_rw_nxt       = d_rw;
                        w_wdata_nxt    = d_wdata;
                        w_ram_addr_nxt = d_addr;
                        w_ram_rw_nxt   = d_rw;
                        w_ram_len_nxt  = (d_len == LEN_DW) ? LEN_WORD : d_len;
                        w_ram_din_nxt  = (d_len == LEN_DW) ? d_wdata[63:32]
                                                           : d_wdata[31:0];
                    end else begin
                        w_addr_nxt     = if_addr;
                        w_len_nxt      = LEN_WORD;
                        w_rw_nxt       = 1'b1;
                        w_wdata_nxt    = '0;
                        w_ram_addr_nxt = if_addr;
                        w_ram_rw_nxt   = 1'b1;
                        w_ram_len_nxt  = LEN_WORD;
                        w_ram_din_nxt  = '0;
                    end
                    w_ram_enable_nxt = 1'b1;
                    w_state_nxt      = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (ram_mfc) begin
                    if (r_rw) begin
                        if (r_len == LEN_DW) begin
                            if (r_beat) w_acc_nxt[31:0]  = ram_data_out;
                            else        w_acc_nxt[63:32] = ram_data_out;
                        end else begin
                            w_acc_nxt = {32'd0, ram_data_out};
                        end
                    end
                    w_ram_enable_nxt = 1'b0;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_RELEASE;
                end else if (r_cnt == CNT_LAST) begin
                    w_ram_enable_nxt = 1'b0;
                    w_err_pend_nxt   = 1'b1;
                    w_state_nxt      = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                if (!ram_mfc) begin
                    w_cnt_nxt = '0;
                    if (r_len == LEN_DW && !r_beat) begin
                        // Enable was low this cycle, so the RAM sees a fresh
                        // rising edge for the second beat.
                        w_beat_nxt       = 1'b1;
                        w_ram_addr_nxt   = r_addr + 9'd4;
                        w_ram_din_nxt    = r_wdata[31:0];
                        w_ram_enable_nxt = 1'b1;
                        w_state_nxt      = S_ACCESS;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_err_pend_nxt = 1'b1;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_err_nxt = r_err_pend;
                if (r_grant_data) begin
                    w_d_done_nxt = 1'b1;
                    if (r_err_pend) w_d_rdata_nxt = '0;
                    else if (r_rw)  w_d_rdata_nxt = r_acc;
                end else begin
                    w_if_done_nxt = 1'b1;
                    if (r_err_pend) w_if_rdata_nxt = '0;
                    else            w_if_rdata_nxt = r_acc[31:0];
                end
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant_data <= 1'b0;
            r_last_data  <= 1'b0;   // makes data win the first tie
            r_beat       <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_rw         <= 1'b0;
            r_wdata      <= '0;
            r_acc        <= '0;
            r_err_pend   <= 1'b0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_ram_enable <= 1'b0;
            r_ram_rw     <= 1'b0;
            r_ram_len    <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_data <= w_grant_data_nxt;
            r_last_data  <= w_last_data_nxt;
            r_beat       <= w_beat_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_len        <= w_len_nxt;
            r_rw         <= w_rw_nxt;
            r_wdata      <= w_wdata_nxt;
            r_acc        <= w_acc_nxt;
            r_err_pend   <= w_err_pend_nxt;
            r_if_done    <= w_if_done_nxt;
            r_d_done     <= w_d_done_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_ram_enable <= w_ram_enable_nxt;
            r_ram_rw     <= w_ram_rw_nxt;
            r_ram_len    <= w_ram_len_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_din    <= w_ram_din_nxt;
        end
    end

    assign if_done         = r_if_done;
    assign if_rdata        = r_if_rdata;
    assign d_done          = r_d_done;
    assign d_rdata         = r_d_rdata;
    assign err             = r_err;
    assign busy            = r_busy;
    assign ram_enable      = r_ram_enable;
    assign ram_read_write  = r_ram_rw;
    assign ram_data_length = r_ram_len;
    assign ram_address     = r_ram_addr;
    assign ram_data_in     = r_ram_din;

endmodule

// File: doc/ram_access_controller.md
Name: ram_access_controller

Overview:
- Sequences the byte-addressed 512-byte RAM's enable/mfc handshake.
- Arbitrates it between the instruction-fetch port (word reads only) and the data port (byte/halfword/word/doubleword, read or write).
- Splits a doubleword access into two word beats and enforces an mfc timeout.
- Sits between the control unit/datapath and the RAM; the only master of the RAM pins.

Parameters:
TIMEOUT, 16, max cycles spent in ACCESS or RELEASE per beat before aborting with error
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
if_req  input  1  fetch request, held until if_done
if_addr  input  9  fetch byte address
if_done  output  1  one-cycle completion pulse
if_rdata  output  32  fetched word, valid with if_done, held until next fetch completes
d_req  input  1  data request, held until d_done
d_rw  input  1  1=read, 0=write (same sense as RAM read_write)
d_len  input  2  0=byte, 1=halfword, 2=word, 3=doubleword
d_addr  input  9  data byte address
d_wdata  input  64  write data, right-aligned; doubleword uses [63:0]
d_done  output  1  one-cycle completion pulse
d_rdata  output  64  read data, zero-extended, valid with d_done, held until next data completion
err  output  1  one-cycle pulse coincident with if_done/d_done when the transaction timed out
ram_enable  output  1  to RAM enable
ram_read_write  output  1  to RAM read_write
ram_data_length  output  2  to RAM data_length
ram_address  output  9  to RAM address
ram_data_in  output  32  to RAM data_in
ram_data_out  input  32  from RAM data_out
ram_mfc  input  1  from RAM mfc
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sync, highest priority, including mid-transaction): state=IDLE, all outputs 0, rr pointer=DATA-first, beat=0, counter=0.
- All outputs are registered.
- States: IDLE, ACCESS, RELEASE, DONE.
- IDLE: grant to a requester whose req=1. If both are high, grant the one not granted last; after reset, data wins. Latch the granted requester's addr/len/rw/wdata. Drive ram_* and set ram_enable=1 next cycle. Go to ACCESS.
- Fetch grant: ram_read_write=1, ram_data_length=2 (word).
- Data byte/halfword/word: pass d_len, d_rw and d_addr through; ram_data_in = d_wdata[31:0].
- Data doubleword: two WORD beats.
  - Beat0: addr, ram_data_in=d_wdata[63:32].
  - Beat1: (addr+4) mod 512, 9-bit wrap; ram_data_in=d_wdata[31:0].
  - Read: beat0 data -> d_rdata[63:32], beat1 data -> d_rdata[31:0].
- ACCESS: hold ram_enable=1. On ram_mfc=1, capture ram_data_out (reads), drop ram_enable, reset counter, go to RELEASE.
- RELEASE: hold ram_enable=0 until ram_mfc=0.
  - If beat1 is pending: load beat1 addr/data, ram_enable=1, go to ACCESS.
  - Otherwise go to DONE.
- Because the RAM acts on enable edges, ram_enable is never high in two consecutive beats without an intervening low cycle.
- DONE: one cycle. Pulse if_done or d_done for the granted port. Update the rdata register on reads; writes leave it unchanged. Return to IDLE.
- The requester must drop req in the cycle after it sees done. A req still high in IDLE is treated as a new request.
- Byte/halfword reads: d_rdata = {zeros, ram_data_out} (the RAM returns these zero-extended in the low bits).
- Timeout: the counter increments each cycle in ACCESS/RELEASE. Reaching TIMEOUT forces ram_enable=0 and goes to DONE with err=1. On error, rdata is set to 0 and any remaining beat is abandoned.
- Minimum latency with an immediate-mfc RAM:
  - Single beat: req sampled at edge 0, done visible after edge 3.
  - Doubleword: done visible after edge 5.
- No misalignment checking; addresses pass through unmodified.
- req inputs are ignored outside IDLE; latched fields are stable for the whole transaction.

Test Plan:
- Fetch: after reset, if_req=1, if_addr=0x010, RAM bytes 0x010..0x013 = 12 34 56 78 -> ram_enable high for one ACCESS span, if_done pulse, if_rdata=0x12345678, err=0.
- Doubleword round trip: write d_addr=0x040, d_wdata=0x0123456789ABCDEF, then read it back -> RAM 0x040..0x047 = 01..EF. Read gives d_rdata=0x0123456789ABCDEF with two enable pulses separated by a low cycle.
- Wrap: doubleword write at d_addr=0x1FC -> beat1 ram_address=0x000; bytes 0x000..0x003 hold d_wdata[31:0].
- Arbitration: if_req and d_req both high continuously from reset -> grants alternate data, fetch, data, fetch; no done overlaps.
- Timeout: model ram_mfc stuck 0 with TIMEOUT=16 -> ram_enable drops after 16 ACCESS cycles; d_done and err pulse together; d_rdata=0.
- Reset mid-transaction: assert reset during ACCESS of a doubleword read -> next cycle ram_enable=0, busy=0, no done pulse. A fresh request then completes normally.
